// File: rtl/proc_fl_io_if.sv
// Core-side and stream-side signal bundle for proc_fl_io.
// The slave modport is the I/O unit's view; the master modport is the core/stream side.
interface proc_fl_io_if #(
    parameter int unsigned NBDATA = 23,
    parameter int unsigned NUIOIN = 2,
    parameter int unsigned NUIOOU = 2,
    parameter int unsigned AWI    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1,
    parameter int unsigned AWO    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1
);
    logic                     proc_req_in;
    logic [AWI-1:0]           proc_addr_in;
    logic [NBDATA-1:0]        proc_io_in;
    logic                     proc_out_en;
    logic [AWO-1:0]           proc_addr_out;
    logic [NBDATA-1:0]        proc_io_out;
    logic                     proc_itr;
    logic [NUIOIN*NBDATA-1:0] in_data;
    logic [NUIOIN-1:0]        in_valid;
    logic [NUIOIN-1:0]        in_ready;
    logic [NUIOOU*NBDATA-1:0] out_data;
    logic [NUIOOU-1:0]        out_valid;
    logic [NUIOOU-1:0]        out_ready;
    logic [NUIOIN-1:0]        udf;
    logic [NUIOOU-1:0]        ovf;
    logic                     clr_flags;

    modport slave (
        input  proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_io_out,
        input  in_data, in_valid, out_ready, clr_flags,
        output proc_io_in, proc_itr, in_ready, out_data, out_valid, udf, ovf
    );

    modport master (
        output proc_req_in, proc_addr_in, proc_out_en, proc_addr_out, proc_io_out,
        output in_data, in_valid, out_ready, clr_flags,
        input  proc_io_in, proc_itr, in_ready, out_data, out_valid, udf, ovf
    );
endinterface

// File: rtl/proc_fl_io.sv
// Buffered I/O unit beside core_fl: per-channel input/output FIFOs with valid/ready,
// sticky underflow/overflow flags and a maskable data-arrival interrupt pulse.
module proc_fl_io #(
    parameter int unsigned        NBMANT = 16,
    parameter int unsigned        NBEXPO = 6,
    parameter int unsigned        NUIOIN = 2,
    parameter int unsigned        NUIOOU = 2,
    parameter int unsigned        IDEPTH = 4,
    parameter int unsigned        ODEPTH = 4,
    parameter logic [NUIOIN-1:0]  ITRMSK = '0
) (
    input  logic         clk,
    input  logic         rst,
    proc_fl_io_if.slave  bus
);
    localparam int unsigned NBDATA = NBMANT + NBEXPO + 1;
    localparam int unsigned IAW    = $clog2(IDEPTH);
    localparam int unsigned OAW    = $clog2(ODEPTH);
    localparam int unsigned AWI    = (NUIOIN > 1) ? $clog2(NUIOIN) : 1;
    localparam int unsigned AWO    = (NUIOOU > 1) ? $clog2(NUIOOU) : 1;

    logic [NBDATA-1:0] imem_q [NUIOIN][IDEPTH];
    logic [IAW-1:0]    irp_q  [NUIOIN];
    logic [IAW-1:0]    iwp_q  [NUIOIN];
    logic [IAW:0]      icnt_q [NUIOIN];
    logic [NBDATA-1:0] hold_q [NUIOIN];
    logic [NBDATA-1:0] omem_q [NUIOOU][ODEPTH];
    logic [OAW-1:0]    orp_q  [NUIOOU];
    logic [OAW-1:0]    owp_q  [NUIOOU];
    logic [OAW:0]      ocnt_q [NUIOOU];
    logic [NUIOIN-1:0] udf_q;
    logic [NUIOOU-1:0] ovf_q;
    logic              itr_q;

    logic [NUIOIN-1:0] iempty, ifull, ipush, ipop, iudf_set, irise;
    logic [NUIOOU-1:0] oempty, ofull, opush, opop, oovf_set;

    // Input side: addresses beyond NUIOIN never match a channel, so they read 0 and touch nothing.
    always_comb begin
        iempty       = '0;
        ifull        = '0;
        ipush        = '0;
        ipop         = '0;
        iudf_set     = '0;
        irise        = '0;
        bus.in_ready = '0;
        bus.proc_io_in = '0;
        for (int k = 0; k < NUIOIN; k++) begin
            iempty[k]       = (icnt_q[k] == '0);
            ifull[k]        = (icnt_q[k] == (IAW+1)'(IDEPTH));
            bus.in_ready[k] = !rst && !ifull[k];
            ipush[k]        = bus.in_valid[k] && !rst && !ifull[k];
            irise[k]        = iempty[k] && ipush[k];
            if (bus.proc_addr_in == AWI'(k)) begin
                bus.proc_io_in = iempty[k] ? hold_q[k] : imem_q[k][irp_q[k]];
                ipop[k]        = bus.proc_req_in && !iempty[k];
                iudf_set[k]    = bus.proc_req_in && iempty[k];
            end
        end
    end

    // Output side: a full FIFO still accepts a write when the same channel drains this cycle.
    always_comb begin
        oempty        = '0;
        ofull         = '0;
        opush         = '0;
        opop          = '0;
        oovf_set      = '0;
        bus.out_valid = '0;
        bus.out_data  = '0;
        for (int j = 0; j < NUIOOU; j++) begin
            oempty[j]        = (ocnt_q[j] == '0);
            ofull[j]         = (ocnt_q[j] == (OAW+1)'(ODEPTH));
            opop[j]          = !oempty[j] && bus.out_ready[j];
            bus.out_valid[j] = !oempty[j];
            bus.out_data[j*NBDATA +: NBDATA] = oempty[j] ? '0 : omem_q[j][orp_q[j]];
            if (bus.proc_out_en && bus.proc_addr_out == AWO'(j)) begin
                opush[j]    = !ofull[j] || opop[j];
                oovf_set[j] = ofull[j] && !opop[j];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < NUIOIN; k++) begin
                irp_q[k]  <= '0;
                iwp_q[k]  <= '0;
                icnt_q[k] <= '0;
                hold_q[k] <= '0;
            end
            udf_q <= '0;
            itr_q <= 1'b0;
        end else begin
            for (int k = 0; k < NUIOIN; k++) begin
                if (ipush[k]) iwp_q[k] <= iwp_q[k] + IAW'(1);
                if (ipop[k]) begin
                    irp_q[k]  <= irp_q[k] + IAW'(1);
                    hold_q[k] <= imem_q[k][irp_q[k]];
                end
                icnt_q[k] <= icnt_q[k] + (IAW+1)'(ipush[k]) - (IAW+1)'(ipop[k]);
            end
            udf_q <= bus.clr_flags ? '0 : (udf_q | iudf_set);
            itr_q <= |(irise & ITRMSK);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < NUIOOU; j++) begin
                orp_q[j]  <= '0;
                owp_q[j]  <= '0;
                ocnt_q[j] <= '0;
            end
            ovf_q <= '0;
        end else begin
            for (int j = 0; j < NUIOOU; j++) begin
                if (opush[j]) owp_q[j] <= owp_q[j] + OAW'(1);
                if (opop[j])  orp_q[j] <= orp_q[j] + OAW'(1);
                ocnt_q[j] <= ocnt_q[j] + (OAW+1)'(opush[j]) - (OAW+1)'(opop[j]);
            end
            ovf_q <= bus.clr_flags ? '0 : (ovf_q | oovf_set);
        end
    end

    // Storage needs no reset: pointers and counts decide what is visible.
    always_ff @(posedge clk) begin
        for (int k = 0; k < NUIOIN; k++)
            if (ipush[k]) imem_q[k][iwp_q[k]] <= bus.in_data[k*NBDATA +: NBDATA];
        for (int j = 0; j < NUIOOU; j++)
            if (opush[j]) omem_q[j][owp_q[j]] <= bus.proc_io_out;
    end

    assign bus.udf      = udf_q;
    assign bus.ovf      = ovf_q;
    assign bus.proc_itr = itr_q;

endmodule

// File: tb/tb_proc_fl_io.sv
// Directed bench for proc_fl_io: a cycle table of inputs/expected outputs plus a reset sequence.
module tb_proc_fl_io;
    localparam int unsigned NB = 23;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    proc_fl_io_if #(.NBDATA(NB), .NUIOIN(2), .NUIOOU(2)) bus ();

    proc_fl_io #(
        .NBMANT(16), .NBEXPO(6), .NUIOIN(2), .NUIOOU(2),
        .IDEPTH(4), .ODEPTH(4), .ITRMSK(2'b01)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    typedef struct {
        logic [1:0]    iv;
        logic [NB-1:0] d0, d1;
        logic          req, ra, oe;
        logic [NB-1:0] od;
        logic [1:0]    ordy;
        logic          clr;
        logic [NB-1:0] e_io;
        logic [1:0]    e_irdy, e_ov;
        logic [NB-1:0] e_od0;
        logic [1:0]    e_udf, e_ovf;
        logic          e_itr;
    } vec_t;

    vec_t vq[$];
    int checks = 0;
    int errors = 0;

    task automatic add(input logic [1:0] iv, input logic [NB-1:0] d0, d1, input logic req, ra, oe,
                       input logic [NB-1:0] od, input logic [1:0] ordy, input logic clr,
                       input logic [NB-1:0] e_io, input logic [1:0] e_irdy, e_ov,
                       input logic [NB-1:0] e_od0, input logic [1:0] e_udf, e_ovf,
                       input logic e_itr);
        vec_t v;
        v.iv = iv; v.d0 = d0; v.d1 = d1; v.req = req; v.ra = ra; v.oe = oe; v.od = od;
        v.ordy = ordy; v.clr = clr; v.e_io = e_io; v.e_irdy = e_irdy; v.e_ov = e_ov;
        v.e_od0 = e_od0; v.e_udf = e_udf; v.e_ovf = e_ovf; v.e_itr = e_itr;
        vq.push_back(v);
    endtask

    function automatic logic [63:0] snap();
        return 64'({bus.proc_io_in, bus.in_ready, bus.out_valid, bus.out_data[NB-1:0],
                    bus.udf, bus.ovf, bus.proc_itr});
    endfunction

    task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h expected %h", name, got, exp);
        end
    endtask

    task automatic drive(input vec_t v);
        bus.in_valid      = v.iv;
        bus.in_data       = {v.d1, v.d0};
        bus.proc_req_in   = v.req;
        bus.proc_addr_in  = v.ra;
        bus.proc_out_en   = v.oe;
        bus.proc_io_out   = v.od;
        bus.out_ready     = v.ordy;
        bus.clr_flags     = v.clr;
    endtask

    initial begin
        vec_t idle;
        idle = '{iv: 2'b00, d0: '0, d1: '0, req: 1'b0, ra: 1'b0, oe: 1'b0, od: '0, ordy: 2'b00,
                 clr: 1'b0, e_io: '0, e_irdy: '0, e_ov: '0, e_od0: '0, e_udf: '0, e_ovf: '0,
                 e_itr: 1'b0};
        drive(idle);
        bus.proc_addr_out = 1'b0;

        //  iv  d0     d1     req ra oe od      ordy clr | io     irdy ov  od0     udf ovf itr
        // input FIFO ch0: fill, read back, underflow, clear
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 0,   'h0,   3, 0, 'h0,   0, 0, 0);
        add(1, 'h11,  'h0,   0, 0, 0, 'h0,   0, 0,   'h0,   3, 0, 'h0,   0, 0, 0);
        add(1, 'h22,  'h0,   0, 0, 0, 'h0,   0, 0,   'h11,  3, 0, 'h0,   0, 0, 1);
        add(1, 'h33,  'h0,   0, 0, 0, 'h0,   0, 0,   'h11,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 0, 0, 'h0,   0, 0,   'h11,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 0, 0, 'h0,   0, 0,   'h22,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 1,   'h33,  3, 0, 'h0,   1, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        // input FIFO ch1 (unmasked): overfill, read back four
        add(2, 'h0,   'hA1,  0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(2, 'h0,   'hA2,  0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(2, 'h0,   'hA3,  0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(2, 'h0,   'hA4,  0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(2, 'h0,   'hA5,  0, 0, 0, 'h0,   0, 0,   'h33,  1, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 1, 0, 'h0,   0, 0,   'hA1,  1, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 1, 0, 'h0,   0, 0,   'hA2,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 1, 0, 'h0,   0, 0,   'hA3,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 1, 0, 'h0,   0, 0,   'hA4,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   1, 1, 0, 'h0,   0, 0,   'hA4,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   0, 1, 0, 'h0,   0, 0,   'hA4,  3, 0, 'h0,   2, 0, 0);
        add(0, 'h0,   'h0,   0, 1, 0, 'h0,   0, 1,   'hA4,  3, 0, 'h0,   2, 0, 0);
        add(0, 'h0,   'h0,   0, 1, 0, 'h0,   0, 0,   'hA4,  3, 0, 'h0,   0, 0, 0);
        // output FIFO ch0: five writes with out_ready low, drain, clear
        add(0, 'h0,   'h0,   0, 0, 1, 'h101, 0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h102, 0, 0,   'h33,  3, 1, 'h101, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h103, 0, 0,   'h33,  3, 1, 'h101, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h104, 0, 0,   'h33,  3, 1, 'h101, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h105, 0, 0,   'h33,  3, 1, 'h101, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h101, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h102, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h103, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h104, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 0, 'h0,   0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 1,   'h33,  3, 0, 'h0,   0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        // full output FIFO with simultaneous drain and write, then prove it is still full
        add(0, 'h0,   'h0,   0, 0, 1, 'h201, 0, 0,   'h33,  3, 0, 'h0,   0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h202, 0, 0,   'h33,  3, 1, 'h201, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h203, 0, 0,   'h33,  3, 1, 'h201, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h204, 0, 0,   'h33,  3, 1, 'h201, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h205, 1, 0,   'h33,  3, 1, 'h201, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 0,   'h33,  3, 1, 'h202, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 1, 'h206, 0, 0,   'h33,  3, 1, 'h202, 0, 0, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 0,   'h33,  3, 1, 'h202, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h202, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h203, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h204, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   1, 0,   'h33,  3, 1, 'h205, 0, 1, 0);
        add(0, 'h0,   'h0,   0, 0, 0, 'h0,   0, 0,   'h33,  3, 0, 'h0,   0, 1, 0);

        // In reset: in_ready low, everything else cleared.
        repeat (2) @(negedge clk);
        #1 chk("in_reset", snap(), 64'({23'h0, 2'b00, 2'b00, 23'h0, 2'b00, 2'b00, 1'b0}));
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < vq.size(); i++) begin
            drive(vq[i]);
            #1 chk($sformatf("vec%0d", i), snap(),
                   64'({vq[i].e_io, vq[i].e_irdy, vq[i].e_ov, vq[i].e_od0,
                        vq[i].e_udf, vq[i].e_ovf, vq[i].e_itr}));
            @(negedge clk);
        end
        drive(idle);

        // Reset mid-stream: buffered words and a live interrupt pulse must vanish.
        bus.in_valid    = 2'b01;
        bus.in_data     = {23'h0, 23'h55};
        bus.proc_out_en = 1'b1;
        bus.proc_io_out = 23'h77;
        @(negedge clk);
        drive(idle);
        #1 chk("pre_rst", snap(), 64'({23'h55, 2'b11, 2'b01, 23'h77, 2'b00, 2'b01, 1'b1}));
        rst = 1'b1;
        #1 chk("mid_rst", snap(), 64'({23'h0, 2'b00, 2'b00, 23'h0, 2'b00, 2'b00, 1'b0}));
        @(negedge clk);
        rst = 1'b0;
        #1 chk("post_rst", snap(), 64'({23'h0, 2'b11, 2'b00, 23'h0, 2'b00, 2'b00, 1'b0}));
        @(negedge clk);
        #1 chk("post_rst_idle", snap(), 64'({23'h0, 2'b11, 2'b00, 23'h0, 2'b00, 2'b00, 1'b0}));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
